// File: rtl/led_pkg.sv
// Shared types and defaults for the LED pattern engine and its helpers.
package led_pkg;

    // Shift behaviour selected by the mode switches.
    typedef enum logic [1:0] {
        MODE_FILL_L = 2'd0,
        MODE_FILL_R = 2'd1,
        MODE_ROT_L  = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_e;

    // Travel direction of the bounce pattern.
    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DIV_W = 24;

endpackage

// File: rtl/led_pattern_shifter_if.sv
// Control and display bundle between the board top and the pattern engine.
// The master side drives switches/buttons, the slave side drives the LEDs.
interface led_pattern_shifter_if #(
    parameter int WIDTH = led_pkg::DEFAULT_WIDTH,
    parameter int DIV_W = led_pkg::DEFAULT_DIV_W
);
    logic                load_i;
    logic [WIDTH-1:0]    pattern_i;
    led_pkg::mode_e      mode_i;
    logic                en_i;
    logic [DIV_W-1:0]    div_i;
    logic                step_i;
    logic                off_i;
    logic [WIDTH-1:0]    leds_o;
    logic                tick_o;
    logic                full_o;

    modport master (
        output load_i, pattern_i, mode_i, en_i, div_i, step_i, off_i,
        input  leds_o, tick_o, full_o
    );

    modport slave (
        input  load_i, pattern_i, mode_i, en_i, div_i, step_i, off_i,
        output leds_o, tick_o, full_o
    );
endinterface

// File: rtl/led_tick_div.sv
// Programmable tick divider: emits a registered one-cycle pulse every
// div_i+1 enabled cycles. A clear restarts the period and drops any tick.
module led_tick_div #(
    parameter int DIV_W = 24
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt;
    logic             tick;

    // Count up to div_i, then restart and raise the tick for one cycle.
    // If div_i is lowered below cnt the counter simply wraps around.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clr_i || !en_i) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == div_i) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

    assign tick_o = tick;

endmodule

// File: rtl/led_pattern_shifter.sv
// LED pattern engine: a WIDTH-bit pattern register loaded from switches and
// advanced by the internal tick or a manual step, in one of four shift modes.
module led_pattern_shifter
    import led_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DIV_W = DEFAULT_DIV_W
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    led_pattern_shifter_if.slave  bus
);

    logic [WIDTH-1:0] pattern_q;
    logic [WIDTH-1:0] pattern_d;
    dir_e             dir_q;
    dir_e             dir_d;
    logic             tick;
    logic             shift;

    led_tick_div #(
        .DIV_W (DIV_W)
    ) u_tick_div (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (bus.load_i),
        .en_i   (bus.en_i),
        .div_i  (bus.div_i),
        .tick_o (tick)
    );

    // A tick and a step landing together are one shift event, not two.
    assign shift = tick | bus.step_i;

    // Next pattern and bounce direction: load beats shift beats hold.
    always_comb begin
        pattern_d = pattern_q;
        dir_d     = dir_q;
        if (bus.load_i) begin
            pattern_d = bus.pattern_i;
            dir_d     = DIR_LEFT;
        end else if (shift) begin
            case (bus.mode_i)
                MODE_FILL_L: pattern_d = {pattern_q[WIDTH-2:0], 1'b1};
                MODE_FILL_R: pattern_d = {1'b1, pattern_q[WIDTH-1:1]};
                MODE_ROT_L:  pattern_d = {pattern_q[WIDTH-2:0], pattern_q[WIDTH-1]};
                MODE_BOUNCE: begin
                    if (pattern_q != '0) begin
                        if (dir_q == DIR_LEFT && pattern_q[WIDTH-1]) begin
                            dir_d     = DIR_RIGHT;
                            pattern_d = {1'b0, pattern_q[WIDTH-1:1]};
                        end else if (dir_q == DIR_RIGHT && pattern_q[0]) begin
                            dir_d     = DIR_LEFT;
                            pattern_d = {pattern_q[WIDTH-2:0], 1'b0};
                        end else if (dir_q == DIR_LEFT) begin
                            pattern_d = {pattern_q[WIDTH-2:0], 1'b0};
                        end else begin
                            pattern_d = {1'b0, pattern_q[WIDTH-1:1]};
                        end
                    end
                end
                default: pattern_d = pattern_q;
            endcase
        end
    end

    // Pattern register and bounce direction flop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pattern_q <= '0;
            dir_q     <= DIR_LEFT;
        end else begin
            pattern_q <= pattern_d;
            dir_q     <= dir_d;
        end
    end

    // Blanking only masks the pins; the register keeps running underneath.
    assign bus.leds_o = bus.off_i ? '0 : pattern_q;
    assign bus.tick_o = tick;
    assign bus.full_o = &pattern_q;

endmodule

// File: tb/tb_led_pattern_shifter.sv
// Scoreboard bench for led_pattern_shifter: stimulus pushes expected LED,
// tick and full values; a monitor pops and compares them after each edge.
module tb_led_pattern_shifter;
    import led_pkg::*;

    localparam int W = 16;
    localparam int D = 24;

    typedef struct {
        int          due;
        string       name;
        logic [W-1:0] leds;
        logic        tick;
        logic        full;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   vectors_applied;
    int   miscompares;
    exp_t sb[$];

    led_pattern_shifter_if #(.WIDTH(W), .DIV_W(D)) bus ();

    led_pattern_shifter #(
        .WIDTH (W),
        .DIV_W (D)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time limit reached, queue=%0d required=0", sb.size());
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [W-1:0] leds,
                               input logic tick, input logic full);
        vectors_applied++;
        if (bus.leds_o !== leds || bus.tick_o !== tick || bus.full_o !== full) begin
            miscompares++;
            $display("[TB] FAIL %s: got leds=%h tick=%b full=%b, required leds=%h tick=%b full=%b",
                     name, bus.leds_o, bus.tick_o, bus.full_o, leds, tick, full);
        end
    endtask

    // Monitor: after every rising edge, compare whatever is due this cycle.
    initial begin
        exp_t e;
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                checkOutput(e.name, e.leds, e.tick, e.full);
            end
        end
    end

    // Drive all inputs on the falling edge; they are sampled at the next rise.
    task automatic applyStimulus(input logic load, input logic [W-1:0] pat,
                                 input mode_e mode, input logic en,
                                 input logic [D-1:0] div, input logic step,
                                 input logic off);
        @(negedge clk);
        bus.load_i    = load;
        bus.pattern_i = pat;
        bus.mode_i    = mode;
        bus.en_i      = en;
        bus.div_i     = div;
        bus.step_i    = step;
        bus.off_i     = off;
    endtask

    // Queue the response expected just after the coming rising edge.
    task automatic expectOut(input string name, input logic [W-1:0] leds,
                             input logic tick, input logic full);
        exp_t e;
        e.due  = cyc + 1;
        e.name = name;
        e.leds = leds;
        e.tick = tick;
        e.full = full;
        sb.push_back(e);
    endtask

    task automatic doLoad(input mode_e mode, input logic [W-1:0] pat);
        applyStimulus(1'b1, pat, mode, 1'b0, '0, 1'b0, 1'b0);
        expectOut("load", pat, 1'b0, &pat);
    endtask

    task automatic doStep(input string name, input mode_e mode,
                          input logic [W-1:0] leds, input logic full);
        applyStimulus(1'b0, '0, mode, 1'b0, '0, 1'b1, 1'b0);
        expectOut(name, leds, 1'b0, full);
    endtask

    initial begin
        logic [W-1:0] e;
        logic [W-1:0] tick_leds [14];
        logic         tick_tick [14];
        vectors_applied = 0;
        miscompares     = 0;

        rst_n         = 1'b0;
        bus.load_i    = 1'b0;
        bus.pattern_i = '0;
        bus.mode_i    = MODE_FILL_L;
        bus.en_i      = 1'b0;
        bus.div_i     = '0;
        bus.step_i    = 1'b0;
        bus.off_i     = 1'b0;

        // Reset state while held.
        @(negedge clk);
        expectOut("reset_hold", 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, '0, MODE_FILL_L, 1'b0, '0, 1'b0, 1'b0);
        expectOut("reset_idle", 16'h0000, 1'b0, 1'b0);

        // Fill-left: 17 steps from zero, saturating at all-ones.
        doLoad(MODE_FILL_L, 16'h0000);
        for (int k = 1; k <= 17; k++) begin
            e = (k >= 16) ? 16'hFFFF : ((16'h0001 << k) - 16'h0001);
            doStep("fill_l", MODE_FILL_L, e, (k >= 16));
        end
        applyStimulus(1'b0, '0, MODE_FILL_L, 1'b0, '0, 1'b0, 1'b0);
        expectOut("fill_l_hold", 16'hFFFF, 1'b0, 1'b1);

        // Fill-right from zero.
        doLoad(MODE_FILL_R, 16'h0000);
        doStep("fill_r", MODE_FILL_R, 16'h8000, 1'b0);

        // Rotate-left and blanking.
        doLoad(MODE_ROT_L, 16'h8001);
        doStep("rot_l", MODE_ROT_L, 16'h0003, 1'b0);
        applyStimulus(1'b0, '0, MODE_ROT_L, 1'b0, '0, 1'b0, 1'b1);
        expectOut("off_blank", 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, MODE_ROT_L, 1'b0, '0, 1'b0, 1'b0);
        expectOut("off_restore", 16'h0003, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hFFFF, MODE_ROT_L, 1'b0, '0, 1'b0, 1'b1);
        expectOut("off_full", 16'h0000, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, MODE_ROT_L, 1'b0, '0, 1'b0, 1'b0);
        expectOut("off_full_show", 16'hFFFF, 1'b0, 1'b1);

        // Bounce: walk up to the top, turn, and walk back down.
        doLoad(MODE_BOUNCE, 16'h0001);
        for (int k = 1; k <= 30; k++) begin
            e = (k <= 15) ? (16'h0001 << k) : (16'h0001 << (30 - k));
            doStep("bounce", MODE_BOUNCE, e, 1'b0);
        end
        doLoad(MODE_BOUNCE, 16'h8001);
        doStep("bounce_8001", MODE_BOUNCE, 16'h4000, 1'b0);
        doStep("bounce_right", MODE_BOUNCE, 16'h2000, 1'b0);
        doLoad(MODE_BOUNCE, 16'h0000);
        doStep("bounce_zero", MODE_BOUNCE, 16'h0000, 1'b0);

        // Direction survives a mode change.
        doLoad(MODE_BOUNCE, 16'h8000);
        doStep("dir_turn", MODE_BOUNCE, 16'h4000, 1'b0);
        doStep("dir_fill", MODE_FILL_L, 16'h8001, 1'b0);
        doStep("dir_kept", MODE_BOUNCE, 16'h0002, 1'b0);

        // Internal tick with div=3, load landing on a tick.
        doLoad(MODE_FILL_L, 16'h0000);
        tick_leds = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0001, 16'h0001,
                      16'h0001, 16'h00F0, 16'h00F0, 16'h00F0, 16'h00F0, 16'h00F0, 16'h01E1};
        tick_tick = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int c = 0; c < 14; c++) begin
            applyStimulus((c == 8), 16'h00F0, MODE_FILL_L, 1'b1, 24'd3, 1'b0, 1'b0);
            expectOut("tick_div3", tick_leds[c], tick_tick[c], 1'b0);
        end
        applyStimulus(1'b0, '0, MODE_FILL_L, 1'b0, '0, 1'b0, 1'b0);
        expectOut("tick_stop", 16'h01E1, 1'b0, 1'b0);

        // Tick and step together give a single shift.
        doLoad(MODE_FILL_L, 16'h0000);
        applyStimulus(1'b0, '0, MODE_FILL_L, 1'b1, 24'd1, 1'b0, 1'b0);
        expectOut("coinc_wait", 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, MODE_FILL_L, 1'b1, 24'd1, 1'b0, 1'b0);
        expectOut("coinc_tick", 16'h0000, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, MODE_FILL_L, 1'b1, 24'd1, 1'b1, 1'b0);
        expectOut("coinc_shift", 16'h0001, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, MODE_FILL_L, 1'b0, '0, 1'b0, 1'b0);
        expectOut("coinc_hold", 16'h0001, 1'b0, 1'b0);

        // Asynchronous reset mid-run, with the bounce heading right.
        doLoad(MODE_BOUNCE, 16'h8000);
        doStep("pre_rst_turn", MODE_BOUNCE, 16'h4000, 1'b0);
        applyStimulus(1'b0, '0, MODE_BOUNCE, 1'b1, 24'd0, 1'b0, 1'b0);
        expectOut("pre_rst_tick", 16'h4000, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, MODE_BOUNCE, 1'b1, 24'd0, 1'b0, 1'b0);
        expectOut("pre_rst_shift", 16'h2000, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async", 16'h0000, 1'b0, 1'b0);
        expectOut("rst_mid_hold", 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, MODE_FILL_L, 1'b0, '0, 1'b1, 1'b0);
        rst_n = 1'b1;
        expectOut("post_rst_fill", 16'h0001, 1'b0, 1'b0);
        doStep("post_rst_rot", MODE_ROT_L, 16'h0002, 1'b0);
        doStep("post_rst_dir", MODE_BOUNCE, 16'h0004, 1'b0);

        // Let the monitor drain, bounded.
        applyStimulus(1'b0, '0, MODE_FILL_L, 1'b0, '0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            vectors_applied++;
            miscompares++;
            $display("[TB] FAIL drain: queue=%0d, required 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
